// File: rtl/keypad_tone_ctrl.sv
// Keypad tone controller: debounces the keypad pressed flag, latches the
// key position and produces a fixed-length tone enable with its PWM period.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-low reset
//   pos       - keypad scanner key position 0..15
//   opr       - keypad pressed flag, asynchronous, may bounce
//   n_freq    - PWM period value for the accepted key (saturated at 4095)
//   tone_en   - PWM output enable, high TONE_CYCLES after a press
//   key_valid - one-cycle strobe per accepted press
//   key_last  - last accepted key position
module keypad_tone_ctrl #(
   parameter int DEB_CYCLES  = 50000,
   parameter int TONE_CYCLES = 25000000,
   parameter int BASE_N      = 1000,
   parameter int STEP_N      = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  pos,
   input  logic        opr,
   output logic [11:0] n_freq,
   output logic        tone_en,
   output logic        key_valid,
   output logic [3:0]  key_last
);

   localparam int MAXC = (DEB_CYCLES > TONE_CYCLES) ?
                         DEB_CYCLES : TONE_CYCLES;
   // Counters only ever reach MAXC-1; keep at least one bit.
   localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] TONE_LAST = CW'(TONE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      PLAY,
      WAIT_REL,
      DEB_REL
   } state_t;

   state_t        state;
   logic          oprMeta;
   logic          oprSync;
   logic [CW-1:0] debCnt;
   logic [CW-1:0] toneCnt;
   logic [15:0]   nCalc;
   logic [11:0]   nNext;

   assign nCalc = 16'(BASE_N) + 16'(STEP_N) * {12'd0, pos};
   assign nNext = (nCalc > 16'd4095) ? 12'hFFF : nCalc[11:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oprMeta <= 1'b0;
         oprSync <= 1'b0;
      end else begin
         oprMeta <= opr;
         oprSync <= oprMeta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         debCnt    <= '0;
         toneCnt   <= '0;
         n_freq    <= 12'(BASE_N);
         tone_en   <= 1'b0;
         key_valid <= 1'b0;
         key_last  <= 4'd0;
      end else begin
         key_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (oprSync) begin
                  state  <= DEB_PRESS;
                  debCnt <= '0;
               end
            end
            DEB_PRESS: begin
               if (!oprSync) begin
                  state <= IDLE;
               end else if (debCnt == DEB_LAST) begin
                  // pos is taken on the same edge as the sync'd flag
                  key_last  <= pos;
                  n_freq    <= nNext;
                  key_valid <= 1'b1;
                  tone_en   <= 1'b1;
                  toneCnt   <= '0;
                  state     <= PLAY;
               end else begin
                  debCnt <= debCnt + CNT_ONE;
               end
            end
            PLAY: begin
               // Tone length is fixed; opr and pos are ignored here.
               if (toneCnt == TONE_LAST) begin
                  tone_en <= 1'b0;
                  state   <= WAIT_REL;
               end else begin
                  toneCnt <= toneCnt + CNT_ONE;
               end
            end
            WAIT_REL: begin
               if (!oprSync) begin
                  state  <= DEB_REL;
                  debCnt <= '0;
               end
            end
            DEB_REL: begin
               if (oprSync) begin
                  state <= WAIT_REL;
               end else if (debCnt == DEB_LAST) begin
                  state <= IDLE;
               end else begin
                  debCnt <= debCnt + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/keypad_tone_ctrl.md
KEYPAD_TONE_CTRL -- requirements
Module: keypad_tone_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CYCLES, default 50000, meaning cycles `opr` must be stable before a press or release is accepted.
REQ-002 The block SHALL have parameter TONE_CYCLES, default 25000000, meaning cycles `tone_en` stays high after an accepted press.
REQ-003 The block SHALL have parameter BASE_N, default 1000, meaning the PWM period value for key 0.
REQ-004 The block SHALL have parameter STEP_N, default 100, meaning the increment of the PWM period value per key position.
REQ-005 The block SHALL have port `clk`, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port `pos`, input, 4 bits: keypad scanner key position, 0..15.
REQ-008 The block SHALL have port `opr`, input, 1 bit: keypad pressed flag, asynchronous to `clk`, may bounce.
REQ-009 The block SHALL have port `n_freq`, output, 12 bits: period value N consumed by the PWM generator.
REQ-010 The block SHALL have port `tone_en`, output, 1 bit: PWM output enable.
REQ-011 The block SHALL have port `key_valid`, output, 1 bit: one-cycle strobe for each accepted press.
REQ-012 The block SHALL have port `key_last`, output, 4 bits: last accepted key position, for the display.

Function
REQ-013 `opr` SHALL pass through a 2-flop synchronizer before any use; `pos` SHALL be sampled on the same cycle as the synchronized `opr`.
REQ-014 The FSM SHALL have states IDLE, DEB_PRESS, PLAY, WAIT_REL and DEB_REL.
REQ-015 IDLE: when synchronized `opr`=1, go to DEB_PRESS and clear the debounce counter.
REQ-016 DEB_PRESS: the counter SHALL increment while `opr`=1; if `opr`=0 before the count reaches DEB_CYCLES-1, return to IDLE with no output change.
REQ-017 DEB_PRESS: on reaching DEB_CYCLES-1 with `opr` still 1, the next edge SHALL do all of the following:
- latch `pos` into `key_last`;
- load n_freq = BASE_N + STEP_N*pos, computed at 16 bits and saturated to 4095;
- pulse `key_valid` for exactly 1 cycle;
- set `tone_en`=1, clear the tone counter and enter PLAY.
REQ-018 Press-to-`tone_en` latency SHALL be 2 (sync) + DEB_CYCLES + 1 cycles.
REQ-019 PLAY: the tone counter SHALL increment each cycle; after TONE_CYCLES cycles of `tone_en`=1 it SHALL drop `tone_en` and go to WAIT_REL.
REQ-020 PLAY: release of `opr` SHALL NOT shorten the tone, and `pos` changes SHALL be ignored.
REQ-021 WAIT_REL: when `opr`=0, go to DEB_REL.
REQ-022 DEB_REL: `opr` must stay 0 for DEB_CYCLES cycles before returning to IDLE; any `opr`=1 returns to WAIT_REL.
REQ-023 A held key SHALL produce exactly one `key_valid` and one tone, with no auto-repeat.
REQ-024 `n_freq` and `key_last` SHALL hold their values between accepted presses, including after `tone_en` falls.
REQ-025 Counters SHALL be sized as clog2 of the maximum of DEB_CYCLES and TONE_CYCLES, and SHALL never wrap.
REQ-026 Parameter values DEB_CYCLES>=1 and TONE_CYCLES>=1 SHALL be supported.

Reset
REQ-027 `rst`=0 SHALL immediately force the following, regardless of `clk`:
- state IDLE, synchronizer flops 0 and both counters 0;
- n_freq=BASE_N, tone_en=0, key_valid=0, key_last=0.
REQ-028 Reset asserted mid-PLAY SHALL terminate the tone at once.
REQ-029 After release of reset, a key already held SHALL be treated as a new press, debounced normally.

Verification (DEB_CYCLES=4, TONE_CYCLES=20)
REQ-030 Clean press, pos=5 held 40 cycles -> key_valid one pulse, key_last=5, n_freq=1500, tone_en high exactly 20 cycles, single tone only.
REQ-031 Bounce: opr pulses 1-2 cycles wide for 10 cycles, then steady 1 with pos=15 -> exactly one key_valid, n_freq=2500.
REQ-032 Glitch shorter than DEB_CYCLES with no steady press -> no key_valid, tone_en stays 0, n_freq stays 1000.
REQ-033 Release at cycle 3 of PLAY, new press pos=2 during PLAY -> tone runs full 20 cycles, pos=2 ignored; press after release debounce -> n_freq=1200.
REQ-034 rst=0 asserted mid-PLAY between clock edges -> tone_en=0 and n_freq=1000 before the next edge; key held through reset release -> new tone after 2+4+1 cycles.
REQ-035 Saturation with BASE_N=4000, STEP_N=100, pos=3 -> n_freq=4095.
